// File: rtl/enc_binder_array_pkg.sv
// Shared HDC constants, the per-channel bind shift table and bind/FSM enums.
package enc_binder_array_pkg;

   localparam int unsigned HV_DIM          = 1024;
   localparam int unsigned FEATURES_PER_CC = 8;

   // Bind rotation per channel; entries may exceed the rotate width and are reduced by the user.
   localparam int unsigned NUM_SHIFTS = 8;
   localparam int unsigned SHIFTS [NUM_SHIFTS] = '{1, 3, 0, 17, 5, 200, 1023, 2048};

   typedef enum logic {
      ROTATE    = 1'b0,
      SEGMENTED = 1'b1
   } bind_mode_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } bind_state_t;

endpackage

// File: rtl/enc_binder_array_if.sv
// Request/result bundle between an encoder controller and the binder array.
interface enc_binder_array_if #(
   parameter int unsigned HV_DIM = enc_binder_array_pkg::HV_DIM,
   parameter int unsigned NUM_CH = enc_binder_array_pkg::FEATURES_PER_CC / 2
);
   import enc_binder_array_pkg::*;

   logic                           start_encoding;
   bind_mode_t                     mode;
   logic [NUM_CH-1:0][HV_DIM-1:0]  level_hv;
   logic                           busy;
   logic                           done;
   logic                           out_valid;
   logic [NUM_CH-1:0][HV_DIM-1:0]  shifted_hv;

   modport master (
      output start_encoding, mode, level_hv,
      input  busy, done, out_valid, shifted_hv
   );

   modport slave (
      input  start_encoding, mode, level_hv,
      output busy, done, out_valid, shifted_hv
   );

endinterface

// File: rtl/enc_lane_shifter.sv
// Combinational bind shifter: full-width rotate-left or independent per-segment rotate-left.
module enc_lane_shifter #(
   parameter int unsigned HV_DIM = 1024,
   parameter int unsigned SEG_W  = 64,
   parameter int unsigned SH_W   = 10
) (
   input  logic [HV_DIM-1:0]                hv,
   input  logic [SH_W-1:0]                  shift,
   input  enc_binder_array_pkg::bind_mode_t mode,
   output logic [HV_DIM-1:0]                rot_hv
);
   import enc_binder_array_pkg::*;

   localparam int unsigned NUM_SEG = HV_DIM / SEG_W;

   logic [HV_DIM-1:0] full_hv;
   logic [HV_DIM-1:0] seg_hv;

   // shift arrives already reduced below the active width, so shift==0 leaves the wrap term empty
   assign full_hv = (hv << shift) | (hv >> (HV_DIM - 32'(shift)));

   for (genvar k = 0; k < NUM_SEG; k++) begin : g_seg
      logic [SEG_W-1:0] seg;
      assign seg = hv[k*SEG_W +: SEG_W];
      assign seg_hv[k*SEG_W +: SEG_W] = (seg << shift) | (seg >> (SEG_W - 32'(shift)));
   end

   assign rot_hv = (mode == SEGMENTED) ? seg_hv : full_hv;

endmodule

// File: rtl/enc_binder_array.sv
// Binds a pack of channel hypervectors by per-channel rotation, LANES channels per cycle.
module enc_binder_array #(
   parameter int unsigned HV_DIM     = enc_binder_array_pkg::HV_DIM,
   parameter int unsigned NUM_CH     = enc_binder_array_pkg::FEATURES_PER_CC / 2,
   parameter int unsigned LANES      = 4,
   parameter int unsigned SEG_W      = 64,
   parameter int unsigned SHIFT_BASE = 0
) (
   input  logic               clk,
   input  logic               nrst,
   enc_binder_array_if.slave  bus
);
   import enc_binder_array_pkg::*;

   localparam int unsigned BEATS  = NUM_CH / LANES;
   localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int unsigned SH_W   = (HV_DIM > 1) ? $clog2(HV_DIM) : 1;

   if (NUM_CH % LANES != 0) begin : g_chk_lanes
      $error("enc_binder_array: NUM_CH must be a multiple of LANES");
   end
   if (HV_DIM % SEG_W != 0) begin : g_chk_seg
      $error("enc_binder_array: HV_DIM must be a multiple of SEG_W");
   end
   if (SHIFT_BASE + NUM_CH > NUM_SHIFTS) begin : g_chk_shifts
      $error("enc_binder_array: SHIFT_BASE+NUM_CH exceeds the SHIFTS table");
   end

   bind_state_t                    state;
   logic [BEAT_W-1:0]              beat;
   logic [NUM_CH-1:0][HV_DIM-1:0]  buf_hv;
   bind_mode_t                     buf_mode;

   logic [SH_W-1:0]   rot_sh [NUM_CH];
   logic [SH_W-1:0]   seg_sh [NUM_CH];
   logic [CH_W-1:0]   lane_ch [LANES];
   logic [HV_DIM-1:0] lane_hv [LANES];
   logic [SH_W-1:0]   lane_sh [LANES];
   logic [HV_DIM-1:0] lane_out [LANES];

   // Per-channel shifts reduced at elaboration for both rotate widths
   for (genvar c = 0; c < NUM_CH; c++) begin : g_sh
      assign rot_sh[c] = SH_W'(SHIFTS[SHIFT_BASE + c] % HV_DIM);
      assign seg_sh[c] = SH_W'(SHIFTS[SHIFT_BASE + c] % SEG_W);
   end

   // Lane l serves channel beat*LANES+l of the snapshot
   always_comb begin
      for (int l = 0; l < LANES; l++) begin
         lane_ch[l] = CH_W'(32'(beat) * LANES + 32'(l));
         lane_hv[l] = buf_hv[lane_ch[l]];
         lane_sh[l] = (buf_mode == SEGMENTED) ? seg_sh[lane_ch[l]] : rot_sh[lane_ch[l]];
      end
   end

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      enc_lane_shifter #(
         .HV_DIM (HV_DIM),
         .SEG_W  (SEG_W),
         .SH_W   (SH_W)
      ) u_shifter (
         .hv     (lane_hv[l]),
         .shift  (lane_sh[l]),
         .mode   (buf_mode),
         .rot_hv (lane_out[l])
      );
   end

   always_ff @(posedge clk) begin
      if (nrst) begin
         state          <= IDLE;
         beat           <= '0;
         buf_hv         <= '0;
         buf_mode       <= ROTATE;
         bus.busy       <= 1'b0;
         bus.done       <= 1'b0;
         bus.out_valid  <= 1'b0;
         bus.shifted_hv <= '0;
      end else begin
         bus.done <= 1'b0;
         case (state)
            IDLE: begin
               // busy lingers through the done pulse, then drops unless a new start is taken
               bus.busy <= 1'b0;
               if (bus.start_encoding) begin
                  buf_hv        <= bus.level_hv;
                  buf_mode      <= bus.mode;
                  beat          <= '0;
                  bus.busy      <= 1'b1;
                  bus.out_valid <= 1'b0;
                  state         <= RUN;
               end
            end
            RUN: begin
               for (int l = 0; l < LANES; l++) begin
                  bus.shifted_hv[lane_ch[l]] <= lane_out[l];
               end
               beat <= beat + 1'b1;
               if (beat == BEAT_W'(BEATS - 1)) begin
                  state <= DONE;
               end
            end
            DONE: begin
               bus.done      <= 1'b1;
               bus.out_valid <= 1'b1;
               state         <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_enc_binder_array.sv
// Directed bench for enc_binder_array (HV_DIM=16, NUM_CH=4, SEG_W=8) with a LANES=2 and a LANES=4 instance.
module tb_enc_binder_array;
   import enc_binder_array_pkg::*;

   typedef logic [3:0][15:0] pack_t;

   logic clk = 1'b0;
   logic nrst;
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   enc_binder_array_if #(.HV_DIM(16), .NUM_CH(4)) bus  ();
   enc_binder_array_if #(.HV_DIM(16), .NUM_CH(4)) bus1 ();

   enc_binder_array #(
      .HV_DIM(16), .NUM_CH(4), .LANES(2), .SEG_W(8), .SHIFT_BASE(0)
   ) u_dut (
      .clk  (clk),
      .nrst (nrst),
      .bus  (bus)
   );

   enc_binder_array #(
      .HV_DIM(16), .NUM_CH(4), .LANES(4), .SEG_W(8), .SHIFT_BASE(0)
   ) u_dut1 (
      .clk  (clk),
      .nrst (nrst),
      .bus  (bus1)
   );

   // Present a request so it is accepted at the next rising edge; returns #1 into cycle 0.
   task automatic start_op(input bind_mode_t m, input pack_t hv);
      @(negedge clk);
      bus.mode           = m;
      bus.level_hv       = hv;
      bus.start_encoding = 1'b1;
      @(posedge clk);
      #1;
      bus.start_encoding = 1'b0;
   endtask

   // Cycle index of the first done pulse after the accept edge, or -1 after the budget.
   task automatic wait_done(output int cyc);
      cyc = -1;
      for (int c = 1; c <= 10; c++) begin
         @(posedge clk);
         #1;
         if (bus.done) begin
            cyc = c;
            break;
         end
      end
   endtask

   task automatic test_reset();
      pack_t d;
      d = {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
      nrst               = 1'b1;
      bus.start_encoding = 1'b1;
      bus.level_hv       = d;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
      checks++;
      if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", bus.done); end
      checks++;
      if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
      checks++;
      if (bus.shifted_hv !== 64'h0) begin failures++; $display("FAIL reset_shifted got=%h want=0", bus.shifted_hv); end
      @(negedge clk);
      bus.start_encoding = 1'b0;
      nrst               = 1'b0;
   endtask

   task automatic test_mode0();
      pack_t d, e;
      int    cyc;
      d = {16'h0001, 16'hA5A5, 16'h8000, 16'h0001};
      e = {16'h0002, 16'hA5A5, 16'h0004, 16'h0002};
      start_op(ROTATE, d);
      checks++;
      if (bus.busy !== 1'b1) begin failures++; $display("FAIL m0_busy_c0 got=%b want=1", bus.busy); end
      wait_done(cyc);
      checks++;
      if (cyc !== 3) begin failures++; $display("FAIL m0_latency got=%0d want=3", cyc); end
      checks++;
      if (bus.busy !== 1'b1) begin failures++; $display("FAIL m0_busy_done got=%b want=1", bus.busy); end
      checks++;
      if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL m0_out_valid got=%b want=1", bus.out_valid); end
      checks++;
      if (bus.shifted_hv !== e) begin failures++; $display("FAIL m0_result got=%h want=%h", bus.shifted_hv, e); end
      @(posedge clk);
      #1;
      checks++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
         failures++; $display("FAIL m0_after got done=%b busy=%b want 0/0", bus.done, bus.busy);
      end
      checks++;
      if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL m0_valid_hold got=%b want=1", bus.out_valid); end
   endtask

   task automatic test_mode1();
      pack_t d, e;
      int    cyc;
      d = {16'h8001, 16'hA5A5, 16'h00E0, 16'h0080};
      e = {16'h0102, 16'hA5A5, 16'h0007, 16'h0001};
      start_op(SEGMENTED, d);
      checks++;
      if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL m1_valid_drop got=%b want=0", bus.out_valid); end
      wait_done(cyc);
      checks++;
      if (cyc !== 3) begin failures++; $display("FAIL m1_latency got=%0d want=3", cyc); end
      checks++;
      if (bus.shifted_hv !== e) begin failures++; $display("FAIL m1_result got=%h want=%h", bus.shifted_hv, e); end
      repeat (2) @(posedge clk);
   endtask

   task automatic test_start_during_run();
      pack_t d, e, d2;
      int    pulses, first;
      d  = {16'h0001, 16'hA5A5, 16'h8000, 16'h0001};
      e  = {16'h0002, 16'hA5A5, 16'h0004, 16'h0002};
      d2 = {16'h1111, 16'h2222, 16'h3333, 16'h4444};
      start_op(ROTATE, d);
      bus.start_encoding = 1'b1;
      bus.mode           = SEGMENTED;
      bus.level_hv       = d2;
      pulses = 0;
      first  = -1;
      for (int c = 1; c <= 8; c++) begin
         @(posedge clk);
         #1;
         if (c == 3) bus.start_encoding = 1'b0;
         if (bus.done) begin
            pulses++;
            if (first < 0) first = c;
         end
      end
      checks++;
      if (pulses !== 1) begin failures++; $display("FAIL busy_ign_pulses got=%0d want=1", pulses); end
      checks++;
      if (first !== 3) begin failures++; $display("FAIL busy_ign_latency got=%0d want=3", first); end
      checks++;
      if (bus.shifted_hv !== e) begin failures++; $display("FAIL busy_ign_result got=%h want=%h", bus.shifted_hv, e); end
      checks++;
      if (bus.busy !== 1'b0) begin failures++; $display("FAIL busy_ign_idle got=%b want=0", bus.busy); end
   endtask

   task automatic test_reset_mid_run();
      pack_t d, e;
      int    pulses, cyc;
      d = {16'h8001, 16'hF00F, 16'h0100, 16'h1234};
      e = {16'h0003, 16'hF00F, 16'h0800, 16'h2468};
      start_op(ROTATE, d);
      @(posedge clk);
      #1;
      nrst = 1'b1;
      @(posedge clk);
      #1;
      nrst = 1'b0;
      checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.out_valid !== 1'b0) begin
         failures++;
         $display("FAIL midrst_flags got busy=%b done=%b valid=%b want 0/0/0", bus.busy, bus.done, bus.out_valid);
      end
      checks++;
      if (bus.shifted_hv !== 64'h0) begin failures++; $display("FAIL midrst_shifted got=%h want=0", bus.shifted_hv); end
      pulses = 0;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk);
         #1;
         if (bus.done) pulses++;
      end
      checks++;
      if (pulses !== 0) begin failures++; $display("FAIL midrst_no_done got=%0d want=0", pulses); end
      start_op(ROTATE, d);
      wait_done(cyc);
      checks++;
      if (cyc !== 3) begin failures++; $display("FAIL midrst_fresh_latency got=%0d want=3", cyc); end
      checks++;
      if (bus.shifted_hv !== e) begin failures++; $display("FAIL midrst_fresh_result got=%h want=%h", bus.shifted_hv, e); end
   endtask

   task automatic test_back_to_back();
      pack_t d1, e1, d2, e2;
      int    cyc;
      d1 = {16'h8001, 16'hF00F, 16'h0100, 16'h1234};
      e1 = {16'h0003, 16'hF00F, 16'h0800, 16'h2468};
      d2 = {16'h8001, 16'hA5A5, 16'h00E0, 16'h0080};
      e2 = {16'h0102, 16'hA5A5, 16'h0007, 16'h0001};
      repeat (2) @(posedge clk);
      start_op(ROTATE, d1);
      wait_done(cyc);
      checks++;
      if (bus.shifted_hv !== e1) begin failures++; $display("FAIL b2b_first got=%h want=%h", bus.shifted_hv, e1); end
      start_op(SEGMENTED, d2);
      checks++;
      if (bus.out_valid !== 1'b0 || bus.busy !== 1'b1) begin
         failures++; $display("FAIL b2b_accept got valid=%b busy=%b want 0/1", bus.out_valid, bus.busy);
      end
      wait_done(cyc);
      checks++;
      if (cyc !== 3) begin failures++; $display("FAIL b2b_latency got=%0d want=3", cyc); end
      checks++;
      if (bus.shifted_hv !== e2) begin failures++; $display("FAIL b2b_second got=%h want=%h", bus.shifted_hv, e2); end
   endtask

   task automatic test_single_beat();
      pack_t d, e;
      int    cyc;
      d = {16'h0001, 16'hA5A5, 16'h8000, 16'h0001};
      e = {16'h0002, 16'hA5A5, 16'h0004, 16'h0002};
      @(negedge clk);
      bus1.mode           = ROTATE;
      bus1.level_hv       = d;
      bus1.start_encoding = 1'b1;
      @(posedge clk);
      #1;
      bus1.start_encoding = 1'b0;
      cyc = -1;
      for (int c = 1; c <= 10; c++) begin
         @(posedge clk);
         #1;
         if (bus1.done) begin
            cyc = c;
            break;
         end
      end
      checks++;
      if (cyc !== 2) begin failures++; $display("FAIL single_latency got=%0d want=2", cyc); end
      checks++;
      if (bus1.shifted_hv !== e) begin failures++; $display("FAIL single_result got=%h want=%h", bus1.shifted_hv, e); end
   endtask

   initial begin
      nrst                = 1'b1;
      bus.start_encoding  = 1'b0;
      bus.mode            = ROTATE;
      bus.level_hv        = '0;
      bus1.start_encoding = 1'b0;
      bus1.mode           = ROTATE;
      bus1.level_hv       = '0;
      test_reset();
      test_mode0();
      test_mode1();
      test_start_during_run();
      test_reset_mid_run();
      test_back_to_back();
      test_single_beat();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/enc_binder_array.md
ENC_BINDER_ARRAY -- requirements
Module: enc_binder_array

Interface
REQ-001 SHALL have parameter HV_DIM, default 1024, hypervector width in bits.
REQ-002 SHALL have parameter NUM_CH, default FEATURES_PER_CC/2, number of hypervector channels per pack.
REQ-003 SHALL have parameter LANES, default 4, physical shifters instantiated; NUM_CH % LANES == 0 required.
REQ-004 SHALL have parameter SEG_W, default 64, segment width for segmented mode; HV_DIM % SEG_W == 0 required.
REQ-005 SHALL have parameter SHIFT_BASE, default 0, start index of this pack's entries in the package SHIFTS table.
REQ-006 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-007 SHALL have port nrst  input  1  synchronous, active-high reset (name kept for codebase consistency).
REQ-008 SHALL have port start_encoding  input  1  request to bind the presented channels.
REQ-009 SHALL have port mode  input  1  0 = full-width rotate, 1 = segmented rotate; sampled with start.
REQ-010 SHALL have port level_hv  input  HV_DIM x NUM_CH  channel hypervectors; sampled with start.
REQ-011 SHALL have port busy  output  1  high from accepted start until done cycle inclusive.
REQ-012 SHALL have port done  output  1  single-cycle pulse when all channels are bound.
REQ-013 SHALL have port out_valid  output  1  shifted_hv holds a complete result.
REQ-014 SHALL have port shifted_hv  output  HV_DIM x NUM_CH  registered bound hypervectors.

Function
REQ-015 Channel i shift s_i SHALL be SHIFTS[SHIFT_BASE+i]; mode 0: out[(j+s_i) mod HV_DIM] = in[j].
REQ-016 Mode 1: each SEG_W slice k SHALL rotate independently: out[k*SEG_W+((j+s_i) mod SEG_W)] = in[k*SEG_W+j].
REQ-017 FSM states IDLE, RUN, DONE; reset state IDLE.
REQ-018 IDLE with start_encoding=1: snapshot level_hv and mode into input buffer, clear beat counter, clear out_valid, go RUN.
REQ-019 RUN: each cycle, lane l SHALL process channel beat*LANES+l from buffer and write its shifted_hv register; beat increments.
REQ-020 RUN at beat NUM_CH/LANES-1 SHALL go DONE after writing that beat.
REQ-021 DONE: done=1 and out_valid set for one cycle, then IDLE; out_valid stays 1 until next accepted start.
REQ-022 Latency: start sampled cycle 0 -> done high in cycle NUM_CH/LANES+1 (cycles counted from accept edge).
REQ-023 start_encoding while busy SHALL be ignored; no queueing; input changes during RUN SHALL not affect results.
REQ-024 start_encoding in DONE cycle SHALL be ignored; start in the IDLE cycle after DONE SHALL be accepted.
REQ-025 Shift values >= HV_DIM (or >= SEG_W in mode 1) SHALL be reduced modulo the relevant width.
REQ-026 LANES == NUM_CH SHALL yield a single RUN beat, done at cycle 2.

Reset
REQ-027 nrst=1 SHALL force IDLE, beat=0, busy=0, done=0, out_valid=0, all shifted_hv=0, buffer=0.
REQ-028 Reset mid-RUN SHALL abandon the operation; no done pulse for it.
REQ-029 Reset dominates start_encoding in the same cycle.

Structure
REQ-030 HV_DIM, FEATURES_PER_CC, SHIFTS table and a bind_mode_t enum (ROTATE, SEGMENTED) SHALL live in the shared HDC package.
REQ-031 One combinational sub-module enc_lane_shifter (in hv, shift, mode -> out hv) SHALL be instantiated LANES times.
REQ-032 Elaboration SHALL fail on NUM_CH % LANES != 0, HV_DIM % SEG_W != 0, or SHIFT_BASE+NUM_CH beyond SHIFTS.

Verification (HV_DIM=16, NUM_CH=4, LANES=2, SEG_W=8, SHIFTS[0..3]={1,3,0,17})
REQ-033 Mode 0, level_hv={0001,8000,A5A5,0001} -> shifted_hv={0002,0004,A5A5,0002}, done at cycle 3.
REQ-034 Mode 1, level_hv[0]=0080, level_hv[1]=00E0 -> shifted_hv[0]=0001, shifted_hv[1]=0007.
REQ-035 Second start during RUN with different data -> ignored; result matches first data; one done pulse.
REQ-036 nrst=1 at RUN beat 1 -> next cycle all outputs 0, no done; fresh start completes normally.
REQ-037 Back-to-back: start in cycle after DONE -> accepted, out_valid drops, new done 3 cycles later.
